// File: rtl/const_op_arbiter.sv
// const_op_arbiter
// Round-robin sequencer that shares one constant-operation datapath
// (8-bit operand, 2-bit constant select, 1-bit op, 8-bit result) between
// two requesters. A request is accepted in IDLE and its fields are
// registered onto the datapath inputs. The result is sampled DP_LAT
// cycles later and held on the response handshake until the owning
// requester consumes it.
// Optional feature macro: CONST_OP_ARB_STATS_EN adds per-requester
// saturating 16-bit grant counters (grant_cnt0, grant_cnt1).
module const_op_arbiter #(
  parameter int DP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_operand,
  input  logic [3:0]  req_sel,
  input  logic [1:0]  req_op,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_result,
  output logic [7:0]  dp_operand,
  output logic [1:0]  dp_sel,
  output logic        dp_op,
  input  logic [7:0]  dp_result,
  output logic        busy
`ifdef CONST_OP_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The wait counter starts at DP_LAT-1; legal DP_LAT 1..4 fits in 2 bits.
  localparam logic [1:0] LP_WAIT_INIT = 2'(DP_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rr_ptr;
  logic        r_owner;
  logic [1:0]  r_wait_cnt;
  logic [7:0]  r_dp_operand;
  logic [1:0]  r_dp_sel;
  logic        r_dp_op;
  logic [7:0]  r_rsp_result;

  logic        w_winner;
  logic        w_any_valid;
  logic [1:0]  w_req_ready;
  logic        w_accept;
  logic        w_capture;
  logic        w_rsp_done;
  logic [7:0]  w_win_operand;
  logic [1:0]  w_win_sel;
  logic        w_win_op;

  // Pick the winner (pointer first, then the other) and select its fields.
  always_comb begin
    w_any_valid   = |req_valid;
    w_winner      = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    w_win_operand = w_winner ? req_operand[15:8] : req_operand[7:0];
    w_win_sel     = w_winner ? req_sel[3:2]      : req_sel[1:0];
    w_win_op      = w_winner ? req_op[1]         : req_op[0];
  end

  // Next-state and handshake decode; ready and response valid are combinational.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 2'b00;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    rsp_valid    = 2'b00;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_req_ready  = w_winner ? 2'b10 : 2'b01;
          w_accept     = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_wait_cnt == 2'd0) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = r_owner ? 2'b10 : 2'b01;
        if (rsp_ready[r_owner]) begin
          w_rsp_done   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Round-robin pointer: the requester just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_rr_ptr <= 1'b0;
    else if (w_rsp_done) r_rr_ptr <= ~r_owner;
  end

  // Latch the winner onto the datapath inputs; they hold until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_dp_operand <= 8'd0;
      r_dp_sel     <= 2'd0;
      r_dp_op      <= 1'b0;
    end else if (w_accept) begin
      r_owner      <= w_winner;
      r_dp_operand <= w_win_operand;
      r_dp_sel     <= w_win_sel;
      r_dp_op      <= w_win_op;
    end
  end

  // Latency counter: loaded on acceptance, counts down while executing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_wait_cnt <= 2'd0;
    else if (w_accept)                               r_wait_cnt <= LP_WAIT_INIT;
    else if (r_state == ST_EXEC && r_wait_cnt != 0)  r_wait_cnt <= r_wait_cnt - 2'd1;
  end

  // Sample the datapath result once; it stays stable through the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rsp_result <= 8'd0;
    else if (w_capture) r_rsp_result <= dp_result;
  end

`ifdef CONST_OP_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= 16'd0;
      r_grant_cnt1 <= 16'd0;
    end else if (w_accept) begin
      if (!w_winner && r_grant_cnt0 != 16'hFFFF) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_winner  && r_grant_cnt1 != 16'hFFFF) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

  assign req_ready  = w_req_ready;
  assign rsp_result = r_rsp_result;
  assign dp_operand = r_dp_operand;
  assign dp_sel     = r_dp_sel;
  assign dp_op      = r_dp_op;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_const_op_arbiter.sv
// Testbench for const_op_arbiter: one instance with DP_LAT=1 and one with
// DP_LAT=3, each driving a bench datapath stub (op ? operand-sel : operand+sel).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_const_op_arbiter;

  logic        clk;
  logic        rst_n;

  // DP_LAT = 1 instance signals
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_operand;
  logic [3:0]  req_sel;
  logic [1:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic [7:0]  dp_operand;
  logic [1:0]  dp_sel;
  logic        dp_op;
  logic [7:0]  dp_result;
  logic        busy;

  // DP_LAT = 3 instance signals
  logic [1:0]  req_valid3;
  logic [1:0]  req_ready3;
  logic [15:0] req_operand3;
  logic [3:0]  req_sel3;
  logic [1:0]  req_op3;
  logic [1:0]  rsp_valid3;
  logic [1:0]  rsp_ready3;
  logic [7:0]  rsp_result3;
  logic [7:0]  dp_operand3;
  logic [1:0]  dp_sel3;
  logic        dp_op3;
  logic [7:0]  dp_result3;
  logic        busy3;
  logic        stub_force3;

  int tests;
  int fails;

`ifdef CONST_OP_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] grant_cnt0_3;
  logic [15:0] grant_cnt1_3;
`endif

  assign dp_result  = dp_op ? dp_operand - {6'd0, dp_sel} : dp_operand + {6'd0, dp_sel};
  assign dp_result3 = stub_force3 ? 8'hAA :
                      (dp_op3 ? dp_operand3 - {6'd0, dp_sel3} : dp_operand3 + {6'd0, dp_sel3});

  const_op_arbiter #(.DP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand(req_operand), .req_sel(req_sel), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .dp_operand(dp_operand), .dp_sel(dp_sel), .dp_op(dp_op),
    .dp_result(dp_result), .busy(busy)
`ifdef CONST_OP_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  const_op_arbiter #(.DP_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_operand(req_operand3), .req_sel(req_sel3), .req_op(req_op3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .dp_operand(dp_operand3), .dp_sel(dp_sel3), .dp_op(dp_op3),
    .dp_result(dp_result3), .busy(busy3)
`ifdef CONST_OP_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0_3), .grant_cnt1(grant_cnt1_3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; req_operand = 16'd0; req_sel = 4'd0; req_op = 2'b00; rsp_ready = 2'b00;
    req_valid3 = 2'b00; req_operand3 = 16'd0; req_sel3 = 4'd0; req_op3 = 2'b00; rsp_ready3 = 2'b00;
    stub_force3 = 1'b0;
    #12;
    tests++;
    if ({busy, rsp_valid, rsp_result, dp_operand, dp_sel, dp_op, req_ready} !== 23'd0) begin
      fails++;
      $display("[TB] FAIL reset_dut1 outputs got %h want 0",
               {busy, rsp_valid, rsp_result, dp_operand, dp_sel, dp_op, req_ready});
    end
    tests++;
    if ({busy3, rsp_valid3, rsp_result3, dp_operand3, dp_sel3, dp_op3, req_ready3} !== 23'd0) begin
      fails++;
      $display("[TB] FAIL reset_dut3 outputs got %h want 0",
               {busy3, rsp_valid3, rsp_result3, dp_operand3, dp_sel3, dp_op3, req_ready3});
    end
    // With valid asserted during reset, ready follows combinationally (rr_ptr=0)
    req_valid = 2'b10;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++; $display("[TB] FAIL reset_ready_follows got %b want 10", req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01; req_operand = {8'd0, 8'd5}; req_sel = {2'd0, 2'd1}; req_op = 2'b00;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("[TB] FAIL single_ready got %b want 01", req_ready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL single_idle_busy got %b want 0", busy); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    tests++;
    if ({busy, rsp_valid, req_ready} !== 5'b1_00_00) begin
      fails++; $display("[TB] FAIL single_exec busy/rsp_valid/ready got %b want 10000", {busy, rsp_valid, req_ready});
    end
    tests++;
    if ({dp_operand, dp_sel, dp_op} !== {8'd5, 2'd1, 1'b0}) begin
      fails++; $display("[TB] FAIL single_dp got %h want %h", {dp_operand, dp_sel, dp_op}, {8'd5, 2'd1, 1'b0});
    end
    @(negedge clk);
    tests++;
    if ({busy, rsp_valid, rsp_result} !== {1'b1, 2'b01, 8'd6}) begin
      fails++; $display("[TB] FAIL single_rsp got busy=%b valid=%b result=%0d want 1 01 6", busy, rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    tests++;
    if ({busy, rsp_valid, rsp_result} !== {1'b0, 2'b00, 8'd6}) begin
      fails++; $display("[TB] FAIL single_done got busy=%b valid=%b result=%0d want 0 00 6", busy, rsp_valid, rsp_result);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 2'b11; req_operand = {8'd10, 8'd10}; req_sel = {2'd2, 2'd3}; req_op = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("[TB] FAIL sim_first_ready got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    tests++;
    if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL sim_exec_ready got %b want 00", req_ready); end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_result} !== {2'b01, 8'd7}) begin
      fails++; $display("[TB] FAIL sim_rsp0 got valid=%b result=%0d want 01 7", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin fails++; $display("[TB] FAIL sim_second_ready got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    tests++;
    if ({dp_operand, dp_sel, dp_op} !== {8'd10, 2'd2, 1'b0}) begin
      fails++; $display("[TB] FAIL sim_dp1 got %h want %h", {dp_operand, dp_sel, dp_op}, {8'd10, 2'd2, 1'b0});
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_result} !== {2'b10, 8'd12}) begin
      fails++; $display("[TB] FAIL sim_rsp1 got valid=%b result=%0d want 10 12", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("[TB] FAIL sim_rr_back_to_0 got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    // rr_ptr is 0 here; req0 computes 50 - 0 = 50
    req_valid = 2'b01; req_operand = {8'd0, 8'd50}; req_sel = 4'd0; req_op = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b11; req_operand = {8'd99, 8'd99};
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({rsp_valid, rsp_result, req_ready, dp_operand} !== {2'b01, 8'd50, 2'b00, 8'd50}) begin
        fails++;
        $display("[TB] FAIL backpressure_hold cyc %0d got valid=%b result=%0d ready=%b dp=%0d want 01 50 00 50",
                 i, rsp_valid, rsp_result, req_ready, dp_operand);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    tests++;
    if ({rsp_valid, busy} !== 3'b01_1) begin
      fails++; $display("[TB] FAIL backpressure_nonowner got valid=%b busy=%b want 01 1", rsp_valid, busy);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    tests++;
    if ({busy, req_ready} !== 3'b0_10) begin
      fails++; $display("[TB] FAIL backpressure_release got busy=%b ready=%b want 0 10", busy, req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_dp_lat3();
    @(negedge clk);
    req_valid3 = 2'b01; req_operand3 = {8'd0, 8'd200}; req_sel3 = {2'd0, 2'd3}; req_op3 = 2'b00;
    #1;
    tests++;
    if (req_ready3 !== 2'b01) begin fails++; $display("[TB] FAIL lat3_ready got %b want 01", req_ready3); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid3 = 2'b00;
      tests++;
      if ({rsp_valid3, busy3} !== 3'b00_1) begin
        fails++; $display("[TB] FAIL lat3_wait cyc %0d got valid=%b busy=%b want 00 1", i, rsp_valid3, busy3);
      end
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid3, rsp_result3} !== {2'b01, 8'd203}) begin
      fails++; $display("[TB] FAIL lat3_rsp got valid=%b result=%0d want 01 203", rsp_valid3, rsp_result3);
    end
    stub_force3 = 1'b1;
    @(negedge clk);
    tests++;
    if ({rsp_valid3, rsp_result3} !== {2'b01, 8'd203}) begin
      fails++; $display("[TB] FAIL lat3_stable got valid=%b result=%0d want 01 203", rsp_valid3, rsp_result3);
    end
    rsp_ready3 = 2'b01;
    @(negedge clk);
    rsp_ready3 = 2'b00;
    stub_force3 = 1'b0;
    tests++;
    if (busy3 !== 1'b0) begin fails++; $display("[TB] FAIL lat3_done busy got %b want 0", busy3); end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    req_valid = 2'b01; req_operand = {8'd0, 8'd77}; req_sel = {2'd0, 2'd2}; req_op = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    tests++;
    if ({busy, dp_operand} !== {1'b1, 8'd77}) begin
      fails++; $display("[TB] FAIL midexec_pre got busy=%b dp=%0d want 1 77", busy, dp_operand);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, rsp_valid, rsp_result, dp_operand, dp_sel, dp_op, req_ready} !== 23'd0) begin
      fails++; $display("[TB] FAIL midexec_async got %h want 0",
                        {busy, rsp_valid, rsp_result, dp_operand, dp_sel, dp_op, req_ready});
    end
    @(negedge clk);
    tests++;
    if ({busy, rsp_valid} !== 3'b0) begin
      fails++; $display("[TB] FAIL midexec_no_rsp got busy=%b valid=%b want 0 00", busy, rsp_valid);
    end
    rst_n = 1'b1;
    req_valid = 2'b10; req_operand = {8'd30, 8'd0}; req_sel = {2'd1, 2'd0}; req_op = 2'b00;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin fails++; $display("[TB] FAIL midexec_new_ready got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_result} !== {2'b10, 8'd31}) begin
      fails++; $display("[TB] FAIL midexec_new_rsp got valid=%b result=%0d want 10 31", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

`ifdef CONST_OP_ARB_STATS_EN
  task automatic stats_txn(input int idx, input logic [7:0] opnd, input logic [7:0] expect_res);
    req_valid = (idx == 1) ? 2'b10 : 2'b01;
    req_operand = {opnd, opnd}; req_sel = 4'b0101; req_op = 2'b00;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (rsp_result !== expect_res) begin
      fails++; $display("[TB] FAIL stats_txn_result req%0d got %0d want %0d", idx, rsp_result, expect_res);
    end
    rsp_ready = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_stats();
    do_reset();
    stats_txn(0, 8'd1, 8'd2);
    stats_txn(1, 8'd2, 8'd3);
    stats_txn(0, 8'd3, 8'd4);
    stats_txn(1, 8'd4, 8'd5);
    stats_txn(0, 8'd5, 8'd6);
    tests++;
    if ({grant_cnt0, grant_cnt1} !== {16'd3, 16'd2}) begin
      fails++; $display("[TB] FAIL stats_counts got %0d/%0d want 3/2", grant_cnt0, grant_cnt1);
    end
    do_reset();
    tests++;
    if ({grant_cnt0, grant_cnt1} !== 32'd0) begin
      fails++; $display("[TB] FAIL stats_clear got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_dp_lat3();
    test_reset_mid_exec();
`ifdef CONST_OP_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/const_op_arbiter.md
# const_op_arbiter

Sequencer and round-robin arbiter that shares one constant-operation datapath (8-bit operand, 2-bit constant select, 1-bit operation, 8-bit result) between two requesters.
- Accepts one request at a time over a valid/ready handshake.
- Drives the datapath inputs from registers and waits a fixed latency.
- Captures the result and returns it over a response handshake to the granted requester.
- Sits between the lab's control logic and the single shared datapath instance.

## Interface
- DP_LAT, 1, cycles from datapath inputs valid to result sampled; legal 1..4.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted when valid&ready on bit i.
- req_operand  in  16  requester i operand at [8i+7:8i].
- req_sel  in  4  requester i constant select at [2i+1:2i].
- req_op  in  2  requester i operation bit.
- rsp_valid  out  2  response valid, one-hot or zero.
- rsp_ready  in  2  requester i consumes response.
- rsp_result  out  8  captured datapath result, shared by both requesters.
- dp_operand  out  8  to datapath operand input.
- dp_sel  out  2  to datapath constant select.
- dp_op  out  1  to datapath operation.
- dp_result  in  8  from datapath output.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - winner = rr_ptr if req_valid[rr_ptr], else the other requester if its req_valid is set.
  - req_ready[winner] = 1 combinationally; the other bit is 0.
  - On acceptance: latch the winner's operand/sel/op into dp_*, store the winner index, load wait_cnt = DP_LAT-1, go to EXEC.
- EXEC: wait_cnt decrements each cycle. When wait_cnt==0, capture dp_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid[owner] = 1; hold rsp_result stable.
  - On rsp_ready[owner], go to IDLE and set rr_ptr = ~owner.
  - rsp_ready on the non-owner bit is ignored.
- Round robin: after reset rr_ptr = 0. The last-served requester has lowest priority.
- dp_* hold their last values outside EXEC; they change only on acceptance.
- req_valid deasserted before acceptance drops the request with no side effect.
- A requester must hold valid and its fields stable until accepted.

## Timing
- Reset values: state IDLE, rr_ptr 0, dp_operand 0, dp_sel 0, dp_op 0, rsp_result 0, rsp_valid 0, busy 0. req_ready is then 0 unless req_valid is set.
- Acceptance edge T: dp_* valid from T.
- Capture at edge T+DP_LAT; rsp_valid high from T+DP_LAT.
- Minimum request-to-request throughput: DP_LAT+2 cycles (accept, DP_LAT wait, response cycle with rsp_ready=1, return to IDLE).
- Both requesters valid in the same IDLE cycle: rr_ptr wins; the loser is accepted at the next IDLE.
- No request is accepted during EXEC or RESP: req_ready = 00.
- rst_n low at any time, including mid-EXEC or RESP, returns all state to reset values immediately. The in-flight request is lost and no response is issued.

## Configuration
- CONST_OP_ARB_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 16 bits.
  - Each counts accepted requests for its requester and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: no counters, no extra ports; behaviour is otherwise identical.

## Test plan
Bench datapath stub: dp_result = dp_op ? dp_operand - dp_sel : dp_operand + dp_sel; DP_LAT = 1 unless stated.
- Single request: req0 operand 5, sel 1, op 0 -> req_ready[0] same cycle; rsp_valid = 01 one cycle later; rsp_result = 6; busy high from acceptance until the response handshake.
- Simultaneous requests from reset: req0 (10, sel 3, op 1) and req1 (10, sel 2, op 0) -> req0 served first with result 7, then req1 with 12; rr_ptr alternates.
- Back-pressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result stay constant; no new acceptance; a response then returns to IDLE.
- DP_LAT = 3: request (200, sel 3, op 0) -> result 203 with rsp_valid exactly 3 cycles after acceptance; result unchanged if the stub alters dp_result afterwards.
- Reset mid-EXEC: rst_n low one cycle after acceptance -> all outputs return to reset values asynchronously; after release a new req1 is accepted normally.
- With CONST_OP_ARB_STATS_EN: 3 req0 and 2 req1 transactions -> grant_cnt0 = 3, grant_cnt1 = 2; reset clears both.
